// File: rtl/alu_mdu_pkg.sv
// Shared types and helpers for alu_mdu: operation codes, FSM states and
// classification of the multi-cycle operations.
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_ADDU = 4'd5,
    OP_SLT  = 4'd6,
    OP_XOR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_MULU = 4'd9,
    OP_DIV  = 4'd10,
    OP_DIVU = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: one bit per cycle on operand magnitudes,
// with the sign fix-up and divide-by-zero override applied to the final step.
module alu_mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div0,
  output logic             ovf
);
  import alu_mdu_pkg::*;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // hi/lo hold accumulator/multiplier for MUL and remainder/quotient for DIV
  logic [WIDTH-1:0]   hi_q, lo_q, dvs_q, a_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q, neg_lo_q, neg_hi_q, div0_q, ovf_q;
  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, rem_sh;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn   = (op == OP_MUL) || (op == OP_DIV);
    mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b = (sgn && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    diff   = rem_sh[WIDTH-1:0] - dvs_q;
    if (div_q) begin
      nxt_hi = ge ? diff : rem_sh[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Results are taken from the post-step values so the top can latch them on the last step
  always_comb begin
    prod = {nxt_hi, nxt_lo};
    if (neg_lo_q) prod = -prod;
    if (div_q) begin
      res_lo = neg_lo_q ? -nxt_lo : nxt_lo;
      res_hi = neg_hi_q ? -nxt_hi : nxt_hi;
      if (div0_q) begin
        res_lo = '1;
        res_hi = a_q;
      end
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  assign last = (cnt_q == CNT_W'(WIDTH - 1));
  assign div0 = div0_q;
  assign ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= mag_a;
      dvs_q    <= mag_b;
      a_q      <= a;
      cnt_q    <= '0;
      div_q    <= is_div(op);
      neg_lo_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= sgn & a[WIDTH-1];
      div0_q   <= is_div(op) && (b == '0);
      ovf_q    <= (op == OP_DIV) && (a == MIN_VAL) && (b == '1);
    end else if (step) begin
      hi_q  <= nxt_hi;
      lo_q  <= nxt_lo;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked execute-stage ALU with iterative multiply/divide.
// Define ALU_MDU_FAST_MUL_EN to route MUL/MULU through a single-cycle multiplier.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  input  logic             if_need_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             sign,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);
  import alu_mdu_pkg::*;

  // Handshake: a request transfers on a rising edge with in_valid & in_ready;
  // a result transfers with out_valid & out_ready and holds stable until then.
  state_t           state_q, state_d;
  logic             use_iter, load_alu, start_iter, load_iter;
  logic [WIDTH-1:0] alu_lo, alu_hi;
  logic             alu_ovf;
  logic [WIDTH:0]   add_x, sub_x;
  logic             iter_last, iter_div0, iter_ovf;
  logic [WIDTH-1:0] iter_lo, iter_hi;

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_p;
  assign use_iter = is_div(alu_op);
  assign fast_p = (alu_op == OP_MUL)
                ? {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}
                : {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`else
  assign use_iter = is_muldiv(alu_op);
`endif

  always_comb begin
    add_x   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    sub_x   = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    alu_lo  = '0;
    alu_hi  = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_lo  = add_x[WIDTH-1:0];
        alu_ovf = if_need_of & (add_x[WIDTH] ^ add_x[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo  = sub_x[WIDTH-1:0];
        alu_ovf = if_need_of & (sub_x[WIDTH] ^ sub_x[WIDTH-1]);
      end
      OP_SLL:  alu_lo = b << a[CNT_W-2:0];
      OP_OR:   alu_lo = a | b;
      OP_AND:  alu_lo = a & b;
      OP_ADDU: alu_lo = a + b;
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_XOR:  alu_lo = a ^ b;
`ifdef ALU_MDU_FAST_MUL_EN
      OP_MUL, OP_MULU: begin
        alu_lo = fast_p[WIDTH-1:0];
        alu_hi = fast_p[2*WIDTH-1:WIDTH];
      end
`endif
      default: alu_lo = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load_alu   = 1'b0;
    start_iter = 1'b0;
    load_iter  = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        if (use_iter) begin
          start_iter = 1'b1;
          state_d    = ST_BUSY;
        end else begin
          load_alu = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_BUSY: if (iter_last) begin
        load_iter = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (load_alu) begin
      result      <= alu_lo;
      result_hi   <= alu_hi;
      overflow    <= alu_ovf;
      div_by_zero <= 1'b0;
    end else if (load_iter) begin
      result      <= iter_lo;
      result_hi   <= iter_hi;
      overflow    <= iter_ovf;
      div_by_zero <= iter_div0;
    end
  end

  alu_mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start_iter),
    .step   (state_q == ST_BUSY),
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .last   (iter_last),
    .res_lo (iter_lo),
    .res_hi (iter_hi),
    .div0   (iter_div0),
    .ovf    (iter_ovf)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sign      = result[WIDTH-1];
  assign zero      = (result == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_mdu;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready, if_need_of;
  logic [3:0]   alu_op;
  logic [W-1:0] a, b, result, result_hi;
  logic         in_ready, out_valid, sign, zero, overflow, div_by_zero;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hi_q[$];
  logic [1:0]   exp_fl_q[$];

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .if_need_of(if_need_of),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .sign(sign), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit of, output logic [W-1:0] r, output logic [W-1:0] h,
                       output bit ov, output bit d0);
    longint sx, sy, s, smax, smin;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    smax = (longint'(1) <<< 31) - 1;
    smin = -(longint'(1) <<< 31);
    r = '0; h = '0; ov = 1'b0; d0 = 1'b0;
    case (op)
      4'd0: begin s = sx + sy; r = s[31:0]; ov = of && (s > smax || s < smin); end
      4'd1: begin s = sx - sy; r = s[31:0]; ov = of && (s > smax || s < smin); end
      4'd2: r = y << x[4:0];
      4'd3: r = x | y;
      4'd4: r = x & y;
      4'd5: r = x + y;
      4'd6: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd7: r = x ^ y;
      4'd8: begin p = sx * sy; r = p[31:0]; h = p[63:32]; end
      4'd9: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; h = p[63:32]; end
      4'd10: begin
        if (y == 0) begin r = '1; h = x; d0 = 1'b1; end
        else if (x == MIN_V && y == '1) begin r = MIN_V; h = '0; ov = 1'b1; end
        else begin s = sx / sy; r = s[31:0]; s = sx % sy; h = s[31:0]; end
      end
      4'd11: begin
        if (y == 0) begin r = '1; h = x; d0 = 1'b1; end
        else begin r = x / y; h = x % y; end
      end
      default: r = '0;
    endcase
  endtask

  function automatic bit is_iter(input logic [3:0] op);
`ifdef ALU_MDU_FAST_MUL_EN
    return (op == 4'd10) || (op == 4'd11);
`else
    return (op >= 4'd8) && (op <= 4'd11);
`endif
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return MIN_V;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  // driver task: issue one op, wait for the result, optionally hold it before release
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit of, input int hold);
    logic [W-1:0] er, eh;
    logic [1:0] fl;
    bit eov, ed0;
    int lat;
    model(op, x, y, of, er, eh, eov, ed0);
    exp_q.push_back(er);
    exp_hi_q.push_back(eh);
    exp_fl_q.push_back({eov, ed0});
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    alu_op = op; a = x; b = y; if_need_of = of; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'($urandom()); b = 32'($urandom()); alu_op = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_op%0d", op), lat, is_iter(op) ? W + 1 : 1);
    er = exp_q.pop_front();
    eh = exp_hi_q.pop_front();
    fl = exp_fl_q.pop_front();
    check($sformatf("result_op%0d", op), result, er);
    check($sformatf("result_hi_op%0d", op), result_hi, eh);
    check($sformatf("overflow_op%0d", op), overflow, fl[1]);
    check($sformatf("div_by_zero_op%0d", op), div_by_zero, fl[0]);
    check("sign", sign, er[W-1]);
    check("zero", zero, er == 0);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, er);
      check("hold_result_hi", result_hi, eh);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; if_need_of = 1'b0;
    alu_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    reset = 1'b0;

    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 0);
    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    do_op(4'd1, MIN_V, 32'd1, 1'b1, 0);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(4'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 0);
    do_op(4'd2, 32'd36, 32'h0000_0F01, 1'b0, 0);
    do_op(4'd8, -32'sd3, 32'd7, 1'b0, 0);
    do_op(4'd9, -32'sd3, 32'd7, 1'b0, 0);
    do_op(4'd10, -32'sd7, 32'd2, 1'b0, 0);
    do_op(4'd11, 32'd7, 32'd0, 1'b0, 0);
    do_op(4'd10, MIN_V, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(4'd10, 32'd100, -32'sd9, 1'b0, 5);
    do_op(4'd13, 32'd5, 32'd6, 1'b0, 0);

    for (int n = 0; n < 60; n++)
      do_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2));

    // abort a multiply mid-flight with reset
    @(negedge clk);
    alu_op = 4'd8; a = -32'sd3; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    check("abort_result_hi", result_hi, 0);
    check("abort_sign", sign, 0);
    check("abort_zero", zero, 1);
    check("abort_overflow", overflow, 0);
    check("abort_div_by_zero", div_by_zero, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
